countdown_timer: RTL

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   MM:SS countdown timer with start/pause toggle, load, and an expiry pulse.
//   All logic is clocked on clk_100MHz; clk_1Hz, btn_start and btn_load are
//   same-domain levels whose rising edges are detected locally.
//
// Ports
//   clk_100MHz  in   system clock (rising edge)
//   reset       in   synchronous active-high reset
//   clk_1Hz     in   1 Hz square wave; each rising edge is one second
//   btn_start   in   debounced level; rising edge toggles start/pause
//   btn_load    in   debounced level; rising edge loads set_min/set_sec
//   set_min     in   [6:0] minutes to load (clamped to MAX_MIN)
//   set_sec     in   [6:0] seconds to load (clamped to 59)
//   min_tens, min_ones, sec_tens, sec_ones  out  [3:0] BCD remaining time
//   running     out  high while counting
//   done        out  high while expired/finished
//   expired     out  one-cycle pulse on entry to the finished state
// -----------------------------------------------------------------------------
module countdown_timer #(
    parameter int MAX_MIN = 59
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       clk_1Hz,
    input  logic       btn_start,
    input  logic       btn_load,
    input  logic [6:0] set_min,
    input  logic [6:0] set_sec,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       expired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    logic clk_1Hz_d;
    logic btn_start_d;
    logic btn_load_d;

    logic tick_edge;
    logic start_edge;
    logic load_edge;

    logic [6:0] ld_min;
    logic [6:0] ld_sec;
    logic [7:0] ld_min_bcd;
    logic [7:0] ld_sec_bcd;

    logic [3:0] dec_min_tens;
    logic [3:0] dec_min_ones;
    logic [3:0] dec_sec_tens;
    logic [3:0] dec_sec_ones;

    logic count_nonzero;
    logic count_is_one;

    // Binary (0..99) to two BCD digits by repeated subtraction of ten.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] t;
        logic [6:0] r;
        t = '0;
        r = v;
        for (int unsigned i = 0; i < 9; i++) begin
            if (r >= 7'd10) begin
                r = r - 7'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

    assign tick_edge  = clk_1Hz   & ~clk_1Hz_d;
    assign start_edge = btn_start & ~btn_start_d;
    assign load_edge  = btn_load  & ~btn_load_d;

    always_comb begin
        ld_min = (int'(set_min) > MAX_MIN) ? 7'(MAX_MIN) : set_min;
        ld_sec = (set_sec > 7'd59) ? 7'd59 : set_sec;
        ld_min_bcd = to_bcd(ld_min);
        ld_sec_bcd = to_bcd(ld_sec);
    end

    // One-second borrow chain. Only used in RUN, where the count is never
    // 00:00, so min_tens never underflows.
    always_comb begin
        dec_min_tens = min_tens;
        dec_min_ones = min_ones;
        dec_sec_tens = sec_tens;
        dec_sec_ones = sec_ones;
        if (sec_ones != 4'd0) begin
            dec_sec_ones = sec_ones - 4'd1;
        end else begin
            dec_sec_ones = 4'd9;
            if (sec_tens != 4'd0) begin
                dec_sec_tens = sec_tens - 4'd1;
            end else begin
                dec_sec_tens = 4'd5;
                if (min_ones != 4'd0) begin
                    dec_min_ones = min_ones - 4'd1;
                end else begin
                    dec_min_ones = 4'd9;
                    dec_min_tens = min_tens - 4'd1;
                end
            end
        end
    end

    assign count_nonzero = |{min_tens, min_ones, sec_tens, sec_ones};
    assign count_is_one  = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state       <= IDLE;
            min_tens    <= '0;
            min_ones    <= '0;
            sec_tens    <= '0;
            sec_ones    <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
            expired     <= 1'b0;
            clk_1Hz_d   <= 1'b0;
            btn_start_d <= 1'b0;
            btn_load_d  <= 1'b0;
        end else begin
            clk_1Hz_d   <= clk_1Hz;
            btn_start_d <= btn_start;
            btn_load_d  <= btn_load;
            expired     <= 1'b0;

            case (state)
                RUN: begin
                    // Load is ignored here; a tick decrements first, and
                    // reaching 00:00 overrides a simultaneous pause request.
                    if (tick_edge) begin
                        min_tens <= dec_min_tens;
                        min_ones <= dec_min_ones;
                        sec_tens <= dec_sec_tens;
                        sec_ones <= dec_sec_ones;
                        if (count_is_one) begin
                            state   <= DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                            expired <= 1'b1;
                        end else if (start_edge) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end
                    end else if (start_edge) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end

                IDLE, PAUSE, DONE: begin
                    if (load_edge) begin
                        min_tens <= ld_min_bcd[7:4];
                        min_ones <= ld_min_bcd[3:0];
                        sec_tens <= ld_sec_bcd[7:4];
                        sec_ones <= ld_sec_bcd[3:0];
                        state    <= IDLE;
                        running  <= 1'b0;
                        done     <= 1'b0;
                    end else if (start_edge) begin
                        if (state == DONE) begin
                            state    <= IDLE;
                            done     <= 1'b0;
                            min_tens <= '0;
                            min_ones <= '0;
                            sec_tens <= '0;
                            sec_ones <= '0;
                        end else if (state == PAUSE || count_nonzero) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
